mem_interface: RTL and testbench

//   Memory stage downstream of the datapath's MAR/MDR pair. Holds the word-addressed main RAM and runs one

---
 rtl/mem_interface.sv | 137 +++++++++++++
 tb/tb_mem_interface.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_interface.sv
// Word-addressed main RAM behind MAR/MDR: one access per strobe, WAIT_CYCLES wait states, done pulse.
// Optional MEM_ADDR_CHECK_EN adds a fault output for addresses beyond the RAM depth.
module mem_interface #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              busy
`ifdef MEM_ADDR_CHECK_EN
   ,
   output logic              fault
`endif
);

   localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StDone, StHold} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              write_q, write_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              fault_q, fault_d;
   logic              req, enter_done, ram_we, range_err;

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

`ifdef MEM_ADDR_CHECK_EN
   assign range_err = |addr[31:ADDR_W];
   assign fault     = fault_q;
`else
   // Upper address bits wrap silently in this build.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr[31:ADDR_W];
   assign range_err      = 1'b0;
`endif

   // The *_d values of addr/wdata/write/fault describe the access being completed, so the
   // zero-wait case (commit on the acceptance edge) shares the same commit path.
   always_comb begin
      req        = mem_read | mem_write;
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      write_d    = write_q;
      fault_d    = fault_q;
      busy_d     = busy_q;
      rdata_d    = rdata_q;
      done_d     = 1'b0;
      enter_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               addr_d  = addr[ADDR_W-1:0];
               wdata_d = wdata;
               write_d = mem_write;
               fault_d = range_err;
               busy_d  = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d    = StDone;
                  enter_done = 1'b1;
               end else begin
                  state_d = StWait;
                  cnt_d   = CntW'(WAIT_CYCLES);
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d    = StDone;
               enter_done = 1'b1;
            end
         end
         StDone: begin
            busy_d  = 1'b0;
            state_d = req ? StHold : StIdle;
         end
         StHold: begin
            if (!req) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (enter_done) begin
         done_d = 1'b1;
         if (!write_d && !fault_d) rdata_d = mem_q[addr_d];
      end
      ram_we = enter_done && write_d && !fault_d;
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         write_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         write_q <= write_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         fault_q <= fault_d;
      end
   end

   // RAM is never cleared; reset only blocks a pending commit.
   always_ff @(posedge clk) begin
      if (clr && ram_we) mem_q[addr_d] <= wdata_d;
   end

   assign rdata = rdata_q;
   assign done  = done_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_mem_interface.sv
// Directed self-checking bench for mem_interface (WAIT_CYCLES=2, ADDR_W=9).
module tb_mem_interface;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        done;
   logic        busy;
`ifdef MEM_ADDR_CHECK_EN
   logic        fault;
`endif

   int errors = 0;
   int checks = 0;

   mem_interface #(
      .DATA_W(32),
      .ADDR_W(9),
      .WAIT_CYCLES(2)
   ) dut (
      .clk(clk),
      .clr(clr),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .addr(addr),
      .wdata(wdata),
      .rdata(rdata),
      .done(done),
      .busy(busy)
`ifdef MEM_ADDR_CHECK_EN
      ,
      .fault(fault)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One strobe-driven access; returns edges until done and the rdata seen with done.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd_val);
      mem_read  = rd;
      mem_write = wr;
      addr      = a;
      wdata     = d;
      lat       = 0;
      step();
      lat++;
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      while (done !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      rd_val    = rdata;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      step();
      check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
   endtask

   int          lat;
   int          pulses;
   logic        busy_hold;
   logic [31:0] rv;

   initial begin
      // Reset
      step();
      step();
      check("rst_rdata", rdata, 32'h0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
`ifdef MEM_ADDR_CHECK_EN
      check("rst_fault", {31'b0, fault}, 32'd0);
`endif
      clr = 1'b1;
      step();

      // Write then read back
      access("wr05", 1'b0, 1'b1, 32'h05, 32'hDEADBEEF, lat, rv);
      check("wr05_lat", lat, 3);
      check("wr05_busy_after", {31'b0, busy}, 32'd0);
      access("rd05", 1'b1, 1'b0, 32'h05, 32'h0, lat, rv);
      check("rd05_lat", lat, 3);
      check("rd05_data", rv, 32'hDEADBEEF);
      step();
      check("rd05_hold", rdata, 32'hDEADBEEF);

      // Held strobe: one access only, busy low in HOLD
      mem_read  = 1'b1;
      addr      = 32'h10;
      pulses    = 0;
      busy_hold = 1'bx;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (done === 1'b1) pulses++;
         if (i == 6) busy_hold = busy;
      end
      check("held_pulses", pulses, 1);
      check("held_busy_hold", {31'b0, busy_hold}, 32'd0);
      mem_read = 1'b0;
      step();
      check("held_busy_idle", {31'b0, busy}, 32'd0);

      // Priority and address/data latch
      access("wr21", 1'b0, 1'b1, 32'h21, 32'h21212121, lat, rv);
      mem_read  = 1'b1;
      mem_write = 1'b1;
      addr      = 32'h20;
      wdata     = 32'h1234;
      step();
      addr  = 32'h21;
      wdata = 32'hFFFFFFFF;
      lat   = 1;
      while (done !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      check("prio_lat", lat, 3);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      step();
      access("rd20", 1'b1, 1'b0, 32'h20, 32'h0, lat, rv);
      check("rd20_data", rv, 32'h00001234);
      access("rd21", 1'b1, 1'b0, 32'h21, 32'h0, lat, rv);
      check("rd21_data", rv, 32'h21212121);

      // Reset abort
      access("wr30_zero", 1'b0, 1'b1, 32'h30, 32'h0, lat, rv);
      mem_write = 1'b1;
      addr      = 32'h30;
      wdata     = 32'hAAAA5555;
      step();
      step();
      clr       = 1'b0;
      mem_write = 1'b0;
      step();
      check("abort_done", {31'b0, done}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      clr = 1'b1;
      access("rd30", 1'b1, 1'b0, 32'h30, 32'h0, lat, rv);
      check("rd30_lat", lat, 3);
      check("rd30_data", rv, 32'h0);

      // Out-of-range address
      mem_write = 1'b1;
      addr      = 32'h205;
      wdata     = 32'h55667788;
      lat       = 0;
      while (done !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      check("oor_lat", lat, 3);
`ifdef MEM_ADDR_CHECK_EN
      check("oor_fault", {31'b0, fault}, 32'd1);
`endif
      mem_write = 1'b0;
      step();
      access("rd005", 1'b1, 1'b0, 32'h005, 32'h0, lat, rv);
`ifdef MEM_ADDR_CHECK_EN
      check("oor_ram_kept", rv, 32'hDEADBEEF);
      check("oor_fault_clr", {31'b0, fault}, 32'd0);
`else
      check("oor_wrap", rv, 32'h55667788);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
